// File: rtl/control_unit.sv
// Mini SRC sequencing controller: Moore FSM stepping one control state per clock.
// Strobes are decoded from the current state and the opcode in ir[31:27].
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        run,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        R15ctrl,
  output logic        PCin,
  output logic        PCout,
  output logic        IncPC,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MDRread,
  output logic        memWrite,
  output logic        conIn,
  output logic        conOut,
  output logic        InPortout,
  output logic        outPortin,
  output logic [3:0]  ALUselect
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state;
  state_t     last;
  logic [4:0] op;
  logic [3:0] alu_sel;
  logic       is_alu, is_imm, is_ldi, is_mem, is_md, is_nn;

  assign op     = ir[31:27];
  assign is_alu = (op >= 5'd3) && (op <= 5'd11);
  assign is_imm = (op >= 5'd12) && (op <= 5'd14);
  assign is_ldi = (op == OP_LDI);
  assign is_mem = (op == OP_LD) || (op == OP_ST);
  assign is_md  = (op == OP_MUL) || (op == OP_DIV);
  assign is_nn  = (op == OP_NEG) || (op == OP_NOT);

  always_comb begin
    alu_sel = 4'b0000;
    if (is_alu) alu_sel = 4'(op - 5'd3);
    else if (op == OP_ANDI) alu_sel = 4'b0010;
    else if (op == OP_ORI) alu_sel = 4'b0011;
    else if (op == OP_MUL) alu_sel = 4'b1001;
    else if (op == OP_DIV) alu_sel = 4'b1010;
    else if (op == OP_NEG) alu_sel = 4'b1011;
    else if (op == OP_NOT) alu_sel = 4'b1100;
  end

  // final execute state per opcode; the step after it is the next fetch
  always_comb begin
    last = S_T3;
    if (is_mem) last = S_T7;
    else if (is_md || op == OP_BR) last = S_T6;
    else if (is_alu || is_imm || is_ldi) last = S_T5;
    else if (is_nn || op == OP_JAL) last = S_T4;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_RESET;
    end else begin
      unique case (state)
        S_RESET: state <= stop ? S_HALT : S_T0;
        S_HALT:  state <= S_HALT;
        S_T0:    state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        default: begin
          if (state == S_T3 && op == OP_HALT)
            state <= S_HALT;
          else if (state == last)
            state <= stop ? S_HALT : S_T0;
          else
            state <= state_t'(state + 4'd1);
        end
      endcase
    end
  end

  always_comb begin
    run = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
    R15ctrl = 1'b0; PCin = 1'b0; PCout = 1'b0; IncPC = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; ZLowout = 1'b0;
    ZHighout = 1'b0; HIin = 1'b0; HIout = 1'b0; LOin = 1'b0;
    LOout = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    MDRread = 1'b0; memWrite = 1'b0; conIn = 1'b0; conOut = 1'b0;
    InPortout = 1'b0; outPortin = 1'b0; ALUselect = 4'b0000;
    run = (state != S_RESET) && (state != S_HALT);
    unique case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin MDRread = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        unique case (1'b1)
          is_alu, is_imm: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          is_ldi, is_mem: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          is_md: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          is_nn: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUselect = alu_sel;
          end
          op == OP_BR:   begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
          op == OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          op == OP_JAL:  begin PCout = 1'b1; R15ctrl = 1'b1; end
          op == OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          op == OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPortin = 1'b1; end
          op == OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          op == OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          is_alu: begin
            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUselect = alu_sel;
          end
          is_imm: begin Cout = 1'b1; Zin = 1'b1; ALUselect = alu_sel; end
          is_ldi, is_mem: begin Cout = 1'b1; Zin = 1'b1; end
          is_md: begin
            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUselect = alu_sel;
          end
          is_nn:        begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          op == OP_BR:  begin PCout = 1'b1; Yin = 1'b1; end
          op == OP_JAL: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          is_alu, is_imm, is_ldi: begin
            ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          is_mem:      begin ZLowout = 1'b1; MARin = 1'b1; end
          is_md:       begin ZLowout = 1'b1; LOin = 1'b1; end
          op == OP_BR: begin Cout = 1'b1; Zin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          op == OP_LD: begin MDRread = 1'b1; MDRin = 1'b1; end
          op == OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          is_md:       begin ZHighout = 1'b1; HIin = 1'b1; end
          op == OP_BR: begin ZLowout = 1'b1; PCin = 1'b1; conOut = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          op == OP_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          op == OP_ST: memWrite = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class state by state
// and compares the full strobe vector against hand-built expectations.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir = 32'h0;
  logic        stop = 1'b0;
  logic run, Gra, Grb, Grc, Rin, Rout, BAout, Cout, R15ctrl, PCin, PCout;
  logic IncPC, IRin, Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout;
  logic MARin, MDRin, MDRout, MDRread, memWrite, conIn, conOut;
  logic InPortout, outPortin;
  logic [3:0] ALUselect;

  int checks = 0;
  int failures = 0;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop), .run(run),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Cout(Cout), .R15ctrl(R15ctrl), .PCin(PCin),
    .PCout(PCout), .IncPC(IncPC), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .ZLowout(ZLowout), .ZHighout(ZHighout), .HIin(HIin), .HIout(HIout),
    .LOin(LOin), .LOout(LOout), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .MDRread(MDRread), .memWrite(memWrite),
    .conIn(conIn), .conOut(conOut), .InPortout(InPortout),
    .outPortin(outPortin), .ALUselect(ALUselect)
  );

  always #5 clk = ~clk;

  logic [33:0] sig;
  assign sig = {run, Gra, Grb, Grc, Rin, Rout, BAout, Cout, R15ctrl, PCin,
                PCout, IncPC, IRin, Yin, Zin, ZLowout, ZHighout, HIin, HIout,
                LOin, LOout, MARin, MDRin, MDRout, MDRread, memWrite, conIn,
                conOut, InPortout, outPortin, ALUselect};

  localparam logic [33:0] RUN   = 34'd1 << 33;
  localparam logic [33:0] GRA   = 34'd1 << 32;
  localparam logic [33:0] GRB   = 34'd1 << 31;
  localparam logic [33:0] GRC   = 34'd1 << 30;
  localparam logic [33:0] RIN   = 34'd1 << 29;
  localparam logic [33:0] ROUT  = 34'd1 << 28;
  localparam logic [33:0] BAOUT = 34'd1 << 27;
  localparam logic [33:0] COUT  = 34'd1 << 26;
  localparam logic [33:0] R15   = 34'd1 << 25;
  localparam logic [33:0] PCIN  = 34'd1 << 24;
  localparam logic [33:0] PCOUT = 34'd1 << 23;
  localparam logic [33:0] INCPC = 34'd1 << 22;
  localparam logic [33:0] IRIN  = 34'd1 << 21;
  localparam logic [33:0] YIN   = 34'd1 << 20;
  localparam logic [33:0] ZIN   = 34'd1 << 19;
  localparam logic [33:0] ZLOW  = 34'd1 << 18;
  localparam logic [33:0] ZHIGH = 34'd1 << 17;
  localparam logic [33:0] HIIN  = 34'd1 << 16;
  localparam logic [33:0] HIOUT = 34'd1 << 15;
  localparam logic [33:0] LOIN  = 34'd1 << 14;
  localparam logic [33:0] MARIN = 34'd1 << 12;
  localparam logic [33:0] MDRIN = 34'd1 << 11;
  localparam logic [33:0] MDROUT= 34'd1 << 10;
  localparam logic [33:0] MDRRD = 34'd1 << 9;
  localparam logic [33:0] MEMWR = 34'd1 << 8;
  localparam logic [33:0] CONIN = 34'd1 << 7;
  localparam logic [33:0] CONOUT= 34'd1 << 6;
  localparam logic [33:0] F0 = RUN | PCOUT | MARIN | INCPC;
  localparam logic [33:0] F1 = RUN | MDRRD | MDRIN;
  localparam logic [33:0] F2 = RUN | MDROUT | IRIN;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sig !== 34'h0) begin
        failures++;
        $display("FAIL reset[%0d] got=%h want=%h", i, sig, 34'h0);
      end
    end
    clr = 1'b0;
    tick();
    checks++;
    if (sig !== F0) begin
      failures++;
      $display("FAIL reset_release got=%h want=%h", sig, F0);
    end
  endtask

  task automatic test_add();
    logic [33:0] e [6];
    ir = 32'h18918000;
    e = '{F1, F2, RUN | GRB | ROUT | YIN, RUN | GRC | ROUT | ZIN,
          RUN | ZLOW | GRA | RIN, F0};
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (sig !== e[i]) begin
        failures++;
        $display("FAIL add step%0d got=%h want=%h", i + 1, sig, e[i]);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [33:0] e [12];
    // shl then ori; the second ir is applied at the next T0
    e = '{F1, F2, RUN | GRB | ROUT | YIN, RUN | GRC | ROUT | ZIN | 34'h8,
          RUN | ZLOW | GRA | RIN, F0,
          F1, F2, RUN | GRB | ROUT | YIN, RUN | COUT | ZIN | 34'h3,
          RUN | ZLOW | GRA | RIN, F0};
    ir = {5'b01011, 27'h0};
    for (int i = 0; i < 12; i++) begin
      if (i == 6) ir = {5'b01110, 27'h0};
      tick();
      checks++;
      if (sig !== e[i]) begin
        failures++;
        $display("FAIL alu_ops step%0d got=%h want=%h", i, sig, e[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [33:0] e [8];
    ir = {5'b00010, 27'h0};
    e = '{F1, F2, RUN | GRB | BAOUT | YIN, RUN | COUT | ZIN,
          RUN | ZLOW | MARIN, RUN | GRA | ROUT | MDRIN, RUN | MEMWR, F0};
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (sig !== e[i]) begin
        failures++;
        $display("FAIL store step%0d got=%h want=%h", i + 1, sig, e[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [33:0] e [7];
    ir = {5'b10011, 27'h0};
    e = '{F1, F2, RUN | GRA | ROUT | CONIN, RUN | PCOUT | YIN,
          RUN | COUT | ZIN, RUN | ZLOW | PCIN | CONOUT, F0};
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (sig !== e[i]) begin
        failures++;
        $display("FAIL branch step%0d got=%h want=%h", i + 1, sig, e[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] e [13];
    // mul, then mfhi, then neg
    e = '{F1, F2, RUN | GRA | ROUT | YIN, RUN | GRB | ROUT | ZIN | 34'h9,
          RUN | ZLOW | LOIN, RUN | ZHIGH | HIIN, F0,
          F1, F2, RUN | HIOUT | GRA | RIN, F0,
          F1, F2};
    ir = {5'b10000, 27'h0};
    for (int i = 0; i < 13; i++) begin
      if (i == 7) ir = {5'b11000, 27'h0};
      if (i == 11) ir = {5'b10001, 27'h0};
      tick();
      checks++;
      if (sig !== e[i]) begin
        failures++;
        $display("FAIL back_to_back step%0d got=%h want=%h", i, sig, e[i]);
      end
    end
  endtask

  task automatic test_neg_jal();
    logic [33:0] e [7];
    e = '{RUN | GRB | ROUT | ZIN | 34'hB, RUN | ZLOW | GRA | RIN, F0,
          F1, F2, RUN | PCOUT | R15, RUN | GRA | ROUT | PCIN};
    for (int i = 0; i < 7; i++) begin
      if (i == 3) ir = {5'b10101, 27'h0};
      tick();
      checks++;
      if (sig !== e[i]) begin
        failures++;
        $display("FAIL neg_jal step%0d got=%h want=%h", i, sig, e[i]);
      end
    end
    tick();
    checks++;
    if (sig !== F0) begin
      failures++;
      $display("FAIL jal_return got=%h want=%h", sig, F0);
    end
  endtask

  task automatic test_stop();
    logic [33:0] e [8];
    ir = 32'h18918000;
    e = '{F1, F2, RUN | GRB | ROUT | YIN, RUN | GRC | ROUT | ZIN,
          RUN | ZLOW | GRA | RIN, 34'h0, 34'h0, 34'h0};
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) stop = 1'b1;
      if (i == 5) stop = 1'b0;
      checks++;
      if (sig !== e[i]) begin
        failures++;
        $display("FAIL stop step%0d got=%h want=%h", i + 1, sig, e[i]);
      end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    checks++;
    if (sig !== F0) begin
      failures++;
      $display("FAIL stop_recover got=%h want=%h", sig, F0);
    end
  endtask

  task automatic test_halt();
    ir = {5'b11011, 27'h0};
    tick();
    tick();
    tick();
    checks++;
    if (sig !== RUN) begin
      failures++;
      $display("FAIL halt_t3 got=%h want=%h", sig, RUN);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (sig !== 34'h0) begin
        failures++;
        $display("FAIL halt_hold[%0d] got=%h want=%h", i, sig, 34'h0);
      end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    checks++;
    if (sig !== F0) begin
      failures++;
      $display("FAIL halt_recover got=%h want=%h", sig, F0);
    end
  endtask

  task automatic test_clr_mid_ld();
    logic [33:0] e [5];
    ir = {5'b00000, 27'h0};
    e = '{F1, F2, RUN | GRB | BAOUT | YIN, RUN | COUT | ZIN,
          RUN | ZLOW | MARIN};
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (sig !== e[i]) begin
        failures++;
        $display("FAIL ld step%0d got=%h want=%h", i + 1, sig, e[i]);
      end
    end
    clr = 1'b1;
    tick();
    checks++;
    if (sig !== 34'h0) begin
      failures++;
      $display("FAIL clr_mid_ld got=%h want=%h", sig, 34'h0);
    end
    clr = 1'b0;
    tick();
    checks++;
    if (sig !== F0) begin
      failures++;
      $display("FAIL clr_release got=%h want=%h", sig, F0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_store();
    test_branch();
    test_back_to_back();
    test_neg_jal();
    test_stop();
    test_halt();
    test_clr_mid_ld();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
